uart_fifo: RTL and testbench



---
 rtl/uart_fifo.sv | 182 ++++++++++++++++++
 tb/tb_uart_fifo.sv | 424 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_fifo.sv
// Buffered UART front end: CPU-side TX/RX FIFOs draining into the uart core's
// write/busy and valid/read handshakes, with sticky overflow/overrun flags.
module uart_fifo #(
    parameter int DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   reset_ni,
    input  logic                   cpu_wr_i,
    input  logic [7:0]             cpu_tx_data_i,
    input  logic                   cpu_rd_i,
    output logic [7:0]             cpu_rx_data_o,
    input  logic                   clr_flags_i,
    output logic                   tx_full_o,
    output logic                   tx_empty_o,
    output logic                   rx_empty_o,
    output logic [$clog2(DEPTH):0] tx_count_o,
    output logic [$clog2(DEPTH):0] rx_count_o,
    output logic                   tx_overflow_o,
    output logic                   rx_overrun_o,
    output logic                   uart_wr_o,
    output logic [7:0]             uart_tx_data_o,
    input  logic                   uart_busy_i,
    output logic                   uart_rd_o,
    input  logic [7:0]             uart_rx_data_i,
    input  logic                   uart_valid_i
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    typedef enum logic { TX_IDLE, TX_GUARD } txState_t;
    typedef enum logic { RX_IDLE, RX_GUARD } rxState_t;

    logic [7:0]    r_txMem [DEPTH];
    logic [AW-1:0] r_txWrPtr, r_txRdPtr;
    logic [CW-1:0] r_txCount;
    txState_t      r_txState, w_txStateNext;
    logic [1:0]    r_txGuard, w_txGuardNext;
    logic          w_txFull, w_txFifoEmpty, w_txPush, w_txPop;

    logic [7:0]    r_rxMem [DEPTH];
    logic [AW-1:0] r_rxWrPtr, r_rxRdPtr;
    logic [CW-1:0] r_rxCount;
    rxState_t      r_rxState, w_rxStateNext;
    logic [1:0]    r_rxGuard, w_rxGuardNext;
    logic          w_rxFull, w_rxFifoEmpty, w_rxPush, w_rxPop;

    logic          r_txOverflow, r_rxOverrun, r_uartWr, r_uartRd;
    logic [7:0]    r_uartTxData;
    logic          w_txOverflowSet, w_rxOverrunSet;

    assign w_txFull      = (r_txCount == FULL_COUNT);
    assign w_txFifoEmpty = (r_txCount == '0);
    assign w_rxFull      = (r_rxCount == FULL_COUNT);
    assign w_rxFifoEmpty = (r_rxCount == '0);

    // A pop in the same cycle frees a slot, so a write to a full FIFO still lands.
    assign w_txPush        = cpu_wr_i && (!w_txFull || w_txPop);
    assign w_txOverflowSet = cpu_wr_i && w_txFull && !w_txPop;
    assign w_rxPop         = cpu_rd_i && !w_rxFifoEmpty;
    assign w_rxOverrunSet  = (r_rxState == RX_IDLE) && uart_valid_i && w_rxFull;

    always_comb begin
        w_txStateNext = r_txState;
        w_txGuardNext = r_txGuard;
        w_txPop       = 1'b0;
        case (r_txState)
            TX_IDLE: begin
                if (!w_txFifoEmpty && !uart_busy_i) begin
                    w_txStateNext = TX_GUARD;
                    w_txGuardNext = 2'd2;
                    w_txPop       = 1'b1;
                end
            end
            TX_GUARD: begin
                if (r_txGuard <= 2'd1) begin
                    w_txStateNext = TX_IDLE;
                    w_txGuardNext = 2'd0;
                end else begin
                    w_txGuardNext = r_txGuard - 2'd1;
                end
            end
            default: w_txStateNext = TX_IDLE;
        endcase
    end

    always_comb begin
        w_rxStateNext = r_rxState;
        w_rxGuardNext = r_rxGuard;
        w_rxPush      = 1'b0;
        case (r_rxState)
            RX_IDLE: begin
                if (uart_valid_i && !w_rxFull) begin
                    w_rxStateNext = RX_GUARD;
                    w_rxGuardNext = 2'd2;
                    w_rxPush      = 1'b1;
                end
            end
            RX_GUARD: begin
                if (r_rxGuard <= 2'd1) begin
                    w_rxStateNext = RX_IDLE;
                    w_rxGuardNext = 2'd0;
                end else begin
                    w_rxGuardNext = r_rxGuard - 2'd1;
                end
            end
            default: w_rxStateNext = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_txPush) r_txMem[r_txWrPtr] <= cpu_tx_data_i;
        if (w_rxPush) r_rxMem[r_rxWrPtr] <= uart_rx_data_i;
    end

    always_ff @(posedge clk or negedge reset_ni) begin
        if (!reset_ni) begin
            r_txWrPtr <= '0;
            r_txRdPtr <= '0;
            r_txCount <= '0;
            r_rxWrPtr <= '0;
            r_rxRdPtr <= '0;
            r_rxCount <= '0;
        end else begin
            if (w_txPush) r_txWrPtr <= r_txWrPtr + AW'(1);
            if (w_txPop)  r_txRdPtr <= r_txRdPtr + AW'(1);
            case ({w_txPush, w_txPop})
                2'b10:   r_txCount <= r_txCount + CW'(1);
                2'b01:   r_txCount <= r_txCount - CW'(1);
                default: r_txCount <= r_txCount;
            endcase
            if (w_rxPush) r_rxWrPtr <= r_rxWrPtr + AW'(1);
            if (w_rxPop)  r_rxRdPtr <= r_rxRdPtr + AW'(1);
            case ({w_rxPush, w_rxPop})
                2'b10:   r_rxCount <= r_rxCount + CW'(1);
                2'b01:   r_rxCount <= r_rxCount - CW'(1);
                default: r_rxCount <= r_rxCount;
            endcase
        end
    end

    // Set events win over a simultaneous clear so no error is ever lost.
    always_ff @(posedge clk or negedge reset_ni) begin
        if (!reset_ni) begin
            r_txState    <= TX_IDLE;
            r_txGuard    <= 2'd0;
            r_rxState    <= RX_IDLE;
            r_rxGuard    <= 2'd0;
            r_uartWr     <= 1'b0;
            r_uartRd     <= 1'b0;
            r_uartTxData <= 8'h00;
            r_txOverflow <= 1'b0;
            r_rxOverrun  <= 1'b0;
        end else begin
            r_txState <= w_txStateNext;
            r_txGuard <= w_txGuardNext;
            r_rxState <= w_rxStateNext;
            r_rxGuard <= w_rxGuardNext;
            r_uartWr  <= w_txPop;
            r_uartRd  <= w_rxPush;
            if (w_txPop) r_uartTxData <= r_txMem[r_txRdPtr];
            if (w_txOverflowSet)  r_txOverflow <= 1'b1;
            else if (clr_flags_i) r_txOverflow <= 1'b0;
            if (w_rxOverrunSet)   r_rxOverrun <= 1'b1;
            else if (clr_flags_i) r_rxOverrun <= 1'b0;
        end
    end

    assign cpu_rx_data_o  = w_rxFifoEmpty ? 8'h00 : r_rxMem[r_rxRdPtr];
    assign tx_full_o      = w_txFull;
    assign tx_empty_o     = w_txFifoEmpty && (r_txState == TX_IDLE);
    assign rx_empty_o     = w_rxFifoEmpty;
    assign tx_count_o     = r_txCount;
    assign rx_count_o     = r_rxCount;
    assign tx_overflow_o  = r_txOverflow;
    assign rx_overrun_o   = r_rxOverrun;
    assign uart_wr_o      = r_uartWr;
    assign uart_tx_data_o = r_uartTxData;
    assign uart_rd_o      = r_uartRd;

endmodule

// File: tb/tb_uart_fifo.sv
// Scoreboard bench for uart_fifo: TX bytes are queued when written and checked
// as they leave on uart_wr_o; RX bytes are queued when the core offers them.
module tb_uart_fifo;

    localparam int DEPTH = 16;

    logic       clk = 1'b0;
    logic       reset_ni;
    logic       cpu_wr_i;
    logic [7:0] cpu_tx_data_i;
    logic       cpu_rd_i;
    logic [7:0] cpu_rx_data_o;
    logic       clr_flags_i;
    logic       tx_full_o, tx_empty_o, rx_empty_o;
    logic [4:0] tx_count_o, rx_count_o;
    logic       tx_overflow_o, rx_overrun_o;
    logic       uart_wr_o;
    logic [7:0] uart_tx_data_o;
    logic       uart_busy_i;
    logic       uart_rd_o;
    logic [7:0] uart_rx_data_i;
    logic       uart_valid_i;

    int checks = 0;
    int fails  = 0;
    logic [7:0] txQ[$];
    logic [7:0] rxQ[$];

    uart_fifo #(.DEPTH(DEPTH)) dut (
        .clk(clk), .reset_ni(reset_ni),
        .cpu_wr_i(cpu_wr_i), .cpu_tx_data_i(cpu_tx_data_i),
        .cpu_rd_i(cpu_rd_i), .cpu_rx_data_o(cpu_rx_data_o),
        .clr_flags_i(clr_flags_i),
        .tx_full_o(tx_full_o), .tx_empty_o(tx_empty_o), .rx_empty_o(rx_empty_o),
        .tx_count_o(tx_count_o), .rx_count_o(rx_count_o),
        .tx_overflow_o(tx_overflow_o), .rx_overrun_o(rx_overrun_o),
        .uart_wr_o(uart_wr_o), .uart_tx_data_o(uart_tx_data_o),
        .uart_busy_i(uart_busy_i), .uart_rd_o(uart_rd_o),
        .uart_rx_data_i(uart_rx_data_i), .uart_valid_i(uart_valid_i)
    );

    always #5 clk = ~clk;

    // Outputs are observed and inputs changed 1 time unit after each rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Core model: offers one byte, drops valid the cycle after the read strobe.
    task automatic coreSend(input logic [7:0] b, output int latency);
        latency = -1;
        uart_valid_i   = 1'b1;
        uart_rx_data_i = b;
        for (int i = 1; i <= 6; i++) begin
            if (latency < 0) begin
                tick();
                if (uart_rd_o) latency = i;
            end
        end
        if (latency > 0) begin
            tick();
            uart_valid_i = 1'b0;
            tick();
        end
    endtask

    task automatic test_reset();
        checks++;
        if ({uart_wr_o, uart_rd_o, tx_overflow_o, rx_overrun_o, tx_full_o, tx_empty_o, rx_empty_o} !== 7'b0000011) begin
            fails++;
            $display("[TB] FAIL reset_flags: got %b expected %b",
                     {uart_wr_o, uart_rd_o, tx_overflow_o, rx_overrun_o, tx_full_o, tx_empty_o, rx_empty_o}, 7'b0000011);
        end
        checks++;
        if ({tx_count_o, rx_count_o} !== 10'd0) begin
            fails++;
            $display("[TB] FAIL reset_counts: got tx=%0d rx=%0d expected 0 0", tx_count_o, rx_count_o);
        end
        checks++;
        if ({uart_tx_data_o, cpu_rx_data_o} !== 16'h0000) begin
            fails++;
            $display("[TB] FAIL reset_data: got %h %h expected 00 00", uart_tx_data_o, cpu_rx_data_o);
        end
    endtask

    task automatic test_tx_burst();
        int pulses = 0;
        int lastPulse = -100;
        logic [7:0] exp;
        uart_busy_i   = 1'b0;
        txQ.push_back(8'h41);
        cpu_tx_data_i = 8'h41;
        cpu_wr_i      = 1'b1;
        for (int cyc = 1; cyc <= 20; cyc++) begin
            tick();
            if (uart_wr_o) begin
                checks++;
                if (txQ.size() == 0) begin
                    fails++;
                    $display("[TB] FAIL burst_unexpected_wr: got byte %h expected no strobe", uart_tx_data_o);
                end else begin
                    exp = txQ.pop_front();
                    if (uart_tx_data_o !== exp) begin
                        fails++;
                        $display("[TB] FAIL burst_byte: got %h expected %h", uart_tx_data_o, exp);
                    end
                end
                checks++;
                if (pulses == 0 && cyc != 2) begin
                    fails++;
                    $display("[TB] FAIL burst_latency: got cycle %0d expected 2", cyc);
                end else if (pulses > 0 && cyc - lastPulse < 3) begin
                    fails++;
                    $display("[TB] FAIL burst_spacing: got %0d cycles expected >= 3", cyc - lastPulse);
                end
                pulses++;
                lastPulse = cyc;
            end
            if (cyc <= 3) begin
                // wr at cycles 0,1,2; the first byte is popped on the same edge as the second push
                exp = (cyc == 3) ? 8'd2 : 8'd1;
                checks++;
                if (tx_count_o !== exp[4:0]) begin
                    fails++;
                    $display("[TB] FAIL burst_count: cycle %0d got %0d expected %0d", cyc, tx_count_o, exp);
                end
            end
            if (cyc == 1) begin cpu_tx_data_i = 8'h42; txQ.push_back(8'h42); end
            if (cyc == 2) begin cpu_tx_data_i = 8'h43; txQ.push_back(8'h43); end
            if (cyc == 3) cpu_wr_i = 1'b0;
        end
        checks++;
        if (pulses != 3 || txQ.size() != 0) begin
            fails++;
            $display("[TB] FAIL burst_pulses: got %0d strobes expected 3", pulses);
        end
        checks++;
        if ({tx_empty_o, tx_count_o} !== {1'b1, 5'd0}) begin
            fails++;
            $display("[TB] FAIL burst_drained: got empty=%b count=%0d expected 1 0", tx_empty_o, tx_count_o);
        end
    endtask

    task automatic test_tx_overflow();
        uart_busy_i = 1'b1;
        for (int i = 0; i <= DEPTH; i++) begin
            cpu_wr_i      = 1'b1;
            cpu_tx_data_i = (i < DEPTH) ? 8'(8'h10 + i) : 8'h99;
            if (i < DEPTH) txQ.push_back(cpu_tx_data_i);
            tick();
            if (i == DEPTH - 1) begin
                checks++;
                if ({tx_full_o, tx_overflow_o, tx_count_o} !== {1'b1, 1'b0, 5'd16}) begin
                    fails++;
                    $display("[TB] FAIL ovf_full: got full=%b ovf=%b count=%0d expected 1 0 16",
                             tx_full_o, tx_overflow_o, tx_count_o);
                end
            end
        end
        checks++;
        if ({tx_overflow_o, tx_count_o} !== {1'b1, 5'd16}) begin
            fails++;
            $display("[TB] FAIL ovf_set: got ovf=%b count=%0d expected 1 16", tx_overflow_o, tx_count_o);
        end
        cpu_tx_data_i = 8'h77;
        clr_flags_i   = 1'b1;
        tick();
        checks++;
        if (tx_overflow_o !== 1'b1) begin
            fails++;
            $display("[TB] FAIL ovf_set_beats_clear: got %b expected 1", tx_overflow_o);
        end
        cpu_wr_i = 1'b0;
        tick();
        clr_flags_i = 1'b0;
        checks++;
        if ({tx_overflow_o, tx_count_o} !== {1'b0, 5'd16}) begin
            fails++;
            $display("[TB] FAIL ovf_clear: got ovf=%b count=%0d expected 0 16", tx_overflow_o, tx_count_o);
        end
    endtask

    task automatic test_full_push_pop();
        int pulses = 1;
        logic [7:0] exp;
        uart_busy_i   = 1'b0;
        cpu_wr_i      = 1'b1;
        cpu_tx_data_i = 8'hEE;
        txQ.push_back(8'hEE);
        tick();
        cpu_wr_i = 1'b0;
        checks++;
        if ({tx_count_o, tx_overflow_o, uart_wr_o} !== {5'd16, 1'b0, 1'b1}) begin
            fails++;
            $display("[TB] FAIL fullpp_state: got count=%0d ovf=%b wr=%b expected 16 0 1",
                     tx_count_o, tx_overflow_o, uart_wr_o);
        end
        exp = txQ.pop_front();
        checks++;
        if (uart_tx_data_o !== exp) begin
            fails++;
            $display("[TB] FAIL fullpp_first: got %h expected %h", uart_tx_data_o, exp);
        end
        for (int cyc = 0; cyc < 80; cyc++) begin
            tick();
            if (uart_wr_o) begin
                pulses++;
                checks++;
                exp = (txQ.size() > 0) ? txQ.pop_front() : 8'hXX;
                if (uart_tx_data_o !== exp) begin
                    fails++;
                    $display("[TB] FAIL fullpp_drain: got %h expected %h", uart_tx_data_o, exp);
                end
            end
        end
        checks++;
        if (pulses != DEPTH + 1 || tx_empty_o !== 1'b1) begin
            fails++;
            $display("[TB] FAIL fullpp_done: got %0d strobes empty=%b expected 17 1", pulses, tx_empty_o);
        end
        txQ.delete();
    endtask

    task automatic test_rx_path();
        logic [7:0] exp;
        rxQ.push_back(8'h5A);
        uart_valid_i   = 1'b1;
        uart_rx_data_i = 8'h5A;
        tick();
        checks++;
        if ({uart_rd_o, rx_empty_o, rx_count_o, cpu_rx_data_o} !== {1'b1, 1'b0, 5'd1, 8'h5A}) begin
            fails++;
            $display("[TB] FAIL rx_first: got rd=%b empty=%b count=%0d data=%h expected 1 0 1 5a",
                     uart_rd_o, rx_empty_o, rx_count_o, cpu_rx_data_o);
        end
        tick();
        uart_valid_i = 1'b0;
        checks++;
        if (uart_rd_o !== 1'b0) begin
            fails++;
            $display("[TB] FAIL rx_strobe_width: got %b expected 0", uart_rd_o);
        end
        tick();
        exp = rxQ.pop_front();
        checks++;
        if (cpu_rx_data_o !== exp) begin
            fails++;
            $display("[TB] FAIL rx_head: got %h expected %h", cpu_rx_data_o, exp);
        end
        cpu_rd_i = 1'b1;
        tick();
        checks++;
        if ({rx_empty_o, rx_count_o, cpu_rx_data_o} !== {1'b1, 5'd0, 8'h00}) begin
            fails++;
            $display("[TB] FAIL rx_after_pop: got empty=%b count=%0d data=%h expected 1 0 00",
                     rx_empty_o, rx_count_o, cpu_rx_data_o);
        end
        tick();
        cpu_rd_i = 1'b0;
        checks++;
        if (rx_count_o !== 5'd0) begin
            fails++;
            $display("[TB] FAIL rx_pop_empty: got count %0d expected 0", rx_count_o);
        end
    endtask

    task automatic test_rx_full();
        int lat;
        int badLat = 0;
        logic sawRd = 1'b0;
        logic [7:0] exp;
        for (int i = 0; i < DEPTH; i++) begin
            rxQ.push_back(8'(8'h80 + i));
            coreSend(8'(8'h80 + i), lat);
            if (lat != 1) badLat++;
        end
        checks++;
        if (badLat != 0) begin
            fails++;
            $display("[TB] FAIL rxfull_latency: got %0d late strobes expected 0", badLat);
        end
        checks++;
        if ({rx_count_o, rx_overrun_o} !== {5'd16, 1'b0}) begin
            fails++;
            $display("[TB] FAIL rxfull_fill: got count=%0d ovr=%b expected 16 0", rx_count_o, rx_overrun_o);
        end
        uart_valid_i   = 1'b1;
        uart_rx_data_i = 8'hC7;
        for (int k = 0; k < 4; k++) begin
            tick();
            if (uart_rd_o) sawRd = 1'b1;
        end
        checks++;
        if ({sawRd, rx_overrun_o, rx_count_o} !== {1'b0, 1'b1, 5'd16}) begin
            fails++;
            $display("[TB] FAIL rxfull_overrun: got rd=%b ovr=%b count=%0d expected 0 1 16",
                     sawRd, rx_overrun_o, rx_count_o);
        end
        exp = rxQ.pop_front();
        checks++;
        if (cpu_rx_data_o !== exp) begin
            fails++;
            $display("[TB] FAIL rxfull_head: got %h expected %h", cpu_rx_data_o, exp);
        end
        cpu_rd_i = 1'b1;
        tick();
        cpu_rd_i = 1'b0;
        rxQ.push_back(8'hC7);
        for (int k = 0; k < 4; k++) begin
            if (!uart_rd_o) tick();
        end
        checks++;
        if ({uart_rd_o, rx_count_o} !== {1'b1, 5'd16}) begin
            fails++;
            $display("[TB] FAIL rxfull_accept: got rd=%b count=%0d expected 1 16", uart_rd_o, rx_count_o);
        end
        tick();
        uart_valid_i = 1'b0;
        tick();
        clr_flags_i = 1'b1;
        tick();
        clr_flags_i = 1'b0;
        checks++;
        if (rx_overrun_o !== 1'b0) begin
            fails++;
            $display("[TB] FAIL rxfull_clear: got %b expected 0", rx_overrun_o);
        end
        while (rxQ.size() > 0) begin
            exp = rxQ.pop_front();
            checks++;
            if (cpu_rx_data_o !== exp) begin
                fails++;
                $display("[TB] FAIL rxfull_drain: got %h expected %h", cpu_rx_data_o, exp);
            end
            cpu_rd_i = 1'b1;
            tick();
        end
        cpu_rd_i = 1'b0;
        checks++;
        if ({rx_empty_o, cpu_rx_data_o} !== {1'b1, 8'h00}) begin
            fails++;
            $display("[TB] FAIL rxfull_empty: got empty=%b data=%h expected 1 00", rx_empty_o, cpu_rx_data_o);
        end
    endtask

    task automatic test_reset_mid_burst();
        int lat;
        logic sawWr = 1'b0;
        coreSend(8'h33, lat);
        uart_busy_i   = 1'b0;
        cpu_wr_i      = 1'b1;
        cpu_tx_data_i = 8'hA1;
        tick();
        cpu_tx_data_i = 8'hA2;
        tick();
        cpu_tx_data_i = 8'hA3;
        checks++;
        if ({uart_wr_o, uart_tx_data_o, rx_count_o} !== {1'b1, 8'hA1, 5'd1}) begin
            fails++;
            $display("[TB] FAIL midrst_pre: got wr=%b data=%h rx=%0d expected 1 a1 1",
                     uart_wr_o, uart_tx_data_o, rx_count_o);
        end
        #2;
        reset_ni = 1'b0;
        #1;
        checks++;
        if ({uart_wr_o, uart_rd_o, uart_tx_data_o, tx_count_o, rx_count_o, tx_empty_o, rx_empty_o, cpu_rx_data_o}
                !== {1'b0, 1'b0, 8'h00, 5'd0, 5'd0, 1'b1, 1'b1, 8'h00}) begin
            fails++;
            $display("[TB] FAIL midrst_async: got wr=%b rd=%b data=%h tx=%0d rx=%0d txe=%b rxe=%b rxd=%h",
                     uart_wr_o, uart_rd_o, uart_tx_data_o, tx_count_o, rx_count_o,
                     tx_empty_o, rx_empty_o, cpu_rx_data_o);
        end
        cpu_wr_i = 1'b0;
        tick();
        tick();
        reset_ni = 1'b1;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (uart_wr_o) sawWr = 1'b1;
        end
        checks++;
        if ({sawWr, tx_empty_o, rx_empty_o} !== 3'b011) begin
            fails++;
            $display("[TB] FAIL midrst_after: got wr=%b txe=%b rxe=%b expected 0 1 1",
                     sawWr, tx_empty_o, rx_empty_o);
        end
    endtask

    initial begin
        reset_ni       = 1'b1;
        cpu_wr_i       = 1'b0;
        cpu_tx_data_i  = 8'h00;
        cpu_rd_i       = 1'b0;
        clr_flags_i    = 1'b0;
        uart_busy_i    = 1'b0;
        uart_rx_data_i = 8'h00;
        uart_valid_i   = 1'b0;
        #1;
        reset_ni = 1'b0;
        #2;
        test_reset();
        tick();
        tick();
        reset_ni = 1'b1;
        tick();
        $display("[TB] TX burst");
        test_tx_burst();
        $display("[TB] TX overflow");
        test_tx_overflow();
        $display("[TB] push/pop on full TX");
        test_full_push_pop();
        $display("[TB] RX path");
        test_rx_path();
        $display("[TB] RX full");
        test_rx_full();
        $display("[TB] async reset mid-burst");
        test_reset_mid_burst();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
